// File: rtl/mii_rx_deframer_if.sv
// ============================================================================
// Module   : mii_rx_deframer_if
// Brief    : PHY receive symbol bus and deframed byte/frame-status bus.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mii_rx_deframer_if #(
    parameter int IN_W  = 4,
    parameter int LEN_W = 11
);
    logic             rx_dv;
    logic             rx_er;
    logic [IN_W-1:0]  rxd;
    logic [7:0]       byte_out;
    logic             byte_valid;
    logic             sof;
    logic             eof;
    logic [LEN_W-1:0] frame_len;
    logic             err_align;
    logic             err_rx;
    logic             err_pre;
    logic             err_long;

    modport master (
        output rx_dv, rx_er, rxd,
        input  byte_out, byte_valid, sof, eof, frame_len,
        input  err_align, err_rx, err_pre, err_long
    );

    modport slave (
        input  rx_dv, rx_er, rxd,
        output byte_out, byte_valid, sof, eof, frame_len,
        output err_align, err_rx, err_pre, err_long
    );
endinterface

`default_nettype wire

// File: rtl/mii_rx_deframer.sv
// ============================================================================
// Module   : mii_rx_deframer
// Brief    : MII/RMII receive deframer - strips preamble/SFD, packs symbols
//            into bytes, reports per-frame length and fault flags on eof.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mii_rx_deframer #(
    parameter int IN_W        = 4,
    parameter int MIN_PRE_SYM = 8,
    parameter int MAX_BYTES   = 1522,
    parameter int LEN_W       = 11
) (
    input  logic                clock,
    input  logic                reset,
    mii_rx_deframer_if.slave    bus
);

    localparam int              c_SPB   = 8 / IN_W;
    localparam int              c_PRE_W = $clog2(MIN_PRE_SYM + 1);
    localparam logic [IN_W-1:0] c_PRE   = (IN_W == 4) ? IN_W'(4'h5) : IN_W'(2'b01);
    localparam logic [IN_W-1:0] c_SFD   = (IN_W == 4) ? IN_W'(4'hD) : IN_W'(2'b11);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_PRE     = 2'd1,
        S_DATA    = 2'd2,
        S_DISCARD = 2'd3
    } state_t;

    state_t             r_state;
    logic               r_armed;
    logic [c_PRE_W-1:0] r_pre_cnt;
    logic [1:0]         r_sym_cnt;
    logic [LEN_W-1:0]   r_byte_cnt;
    logic [7-IN_W:0]    r_shift;
    logic               r_pre_bad;
    logic               r_rx_bad;
    logic               r_long_bad;

    logic [7:0]         r_byte_out;
    logic               r_byte_valid;
    logic               r_sof;
    logic               r_eof;
    logic [LEN_W-1:0]   r_frame_len;
    logic               r_err_align;
    logic               r_err_rx;
    logic               r_err_pre;
    logic               r_err_long;

    logic [7:0]         w_byte;
    logic               w_byte_done;
    logic               w_room;

    assign w_byte      = {bus.rxd, r_shift};
    assign w_byte_done = (r_sym_cnt == 2'(c_SPB - 1));
    assign w_room      = (r_byte_cnt < LEN_W'(MAX_BYTES));

    // r_armed stays low after reset until rx_dv is seen low, so a frame that
    // was in flight across reset is discarded instead of being re-acquired.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_armed      <= 1'b0;
            r_pre_cnt    <= '0;
            r_sym_cnt    <= '0;
            r_byte_cnt   <= '0;
            r_shift      <= '0;
            r_pre_bad    <= 1'b0;
            r_rx_bad     <= 1'b0;
            r_long_bad   <= 1'b0;
            r_byte_out   <= '0;
            r_byte_valid <= 1'b0;
            r_sof        <= 1'b0;
            r_eof        <= 1'b0;
            r_frame_len  <= '0;
            r_err_align  <= 1'b0;
            r_err_rx     <= 1'b0;
            r_err_pre    <= 1'b0;
            r_err_long   <= 1'b0;
        end else begin
            r_byte_valid <= 1'b0;
            r_sof        <= 1'b0;
            r_eof        <= 1'b0;
            r_frame_len  <= '0;
            r_err_align  <= 1'b0;
            r_err_rx     <= 1'b0;
            r_err_pre    <= 1'b0;
            r_err_long   <= 1'b0;
            if (!bus.rx_dv) begin
                r_armed <= 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    if (bus.rx_dv) begin
                        if (r_armed && bus.rxd == c_PRE) begin
                            r_state   <= S_PRE;
                            r_pre_cnt <= c_PRE_W'(1);
                        end else begin
                            r_state <= S_DISCARD;
                        end
                    end
                end
                S_PRE: begin
                    if (!bus.rx_dv) begin
                        r_state <= S_IDLE;
                    end else if (bus.rxd == c_PRE) begin
                        if (r_pre_cnt < c_PRE_W'(MIN_PRE_SYM)) begin
                            r_pre_cnt <= r_pre_cnt + c_PRE_W'(1);
                        end
                    end else if (bus.rxd == c_SFD) begin
                        r_state    <= S_DATA;
                        r_pre_bad  <= (r_pre_cnt < c_PRE_W'(MIN_PRE_SYM));
                        r_rx_bad   <= bus.rx_er;
                        r_long_bad <= 1'b0;
                        r_sym_cnt  <= '0;
                        r_byte_cnt <= '0;
                        r_shift    <= '0;
                    end else begin
                        r_state <= S_DISCARD;
                    end
                end
                S_DATA: begin
                    if (bus.rx_dv) begin
                        r_rx_bad <= r_rx_bad | bus.rx_er;
                        r_shift  <= w_byte[7:IN_W];
                        if (w_byte_done) begin
                            r_sym_cnt <= '0;
                            if (w_room) begin
                                r_byte_out   <= w_byte;
                                r_byte_valid <= 1'b1;
                                r_sof        <= (r_byte_cnt == '0);
                                r_byte_cnt   <= r_byte_cnt + LEN_W'(1);
                            end else begin
                                r_long_bad <= 1'b1;
                            end
                        end else begin
                            r_sym_cnt <= r_sym_cnt + 2'd1;
                        end
                    end else begin
                        // Partial trailing byte is dropped; only flagged.
                        r_eof       <= 1'b1;
                        r_frame_len <= r_byte_cnt;
                        r_err_align <= (r_sym_cnt != 2'd0);
                        r_err_rx    <= r_rx_bad;
                        r_err_pre   <= r_pre_bad;
                        r_err_long  <= r_long_bad;
                        r_state     <= S_IDLE;
                        r_sym_cnt   <= '0;
                        r_byte_cnt  <= '0;
                        r_shift     <= '0;
                        r_pre_bad   <= 1'b0;
                        r_rx_bad    <= 1'b0;
                        r_long_bad  <= 1'b0;
                    end
                end
                S_DISCARD: begin
                    if (!bus.rx_dv) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.byte_out   = r_byte_out;
    assign bus.byte_valid = r_byte_valid;
    assign bus.sof        = r_sof;
    assign bus.eof        = r_eof;
    assign bus.frame_len  = r_frame_len;
    assign bus.err_align  = r_err_align;
    assign bus.err_rx     = r_err_rx;
    assign bus.err_pre    = r_err_pre;
    assign bus.err_long   = r_err_long;

endmodule

`default_nettype wire

// File: tb/tb_mii_rx_deframer.sv
// ============================================================================
// Module   : tb_mii_rx_deframer
// Brief    : Scoreboard bench for mii_rx_deframer: two MII instances (large and
//            small MAX_BYTES) sharing one stimulus stream, plus one RMII instance.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mii_rx_deframer;

    localparam int c_MIN_PRE = 8;
    localparam int c_MAX_BIG = 1522;
    localparam int c_MAX_SML = 4;

    typedef struct {
        bit         is_eof;
        logic [7:0] b;
        bit         sof;
        int         len;
        bit         ea;
        bit         erx;
        bit         ep;
        bit         el;
    } ev_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    logic       mii_dv = 1'b0, mii_er = 1'b0;
    logic [3:0] mii_d = '0;
    logic       rmii_dv = 1'b0, rmii_er = 1'b0;
    logic [1:0] rmii_d = '0;

    int  total = 0;
    int  bad = 0;
    bit  mon_en = 1'b0;
    bit  armed = 1'b0;
    ev_t q0[$], q1[$], q2[$];
    logic [3:0] s_q[$];
    bit         e_q[$];

    mii_rx_deframer_if #(.IN_W(4), .LEN_W(11)) bus0 ();
    mii_rx_deframer_if #(.IN_W(4), .LEN_W(11)) bus1 ();
    mii_rx_deframer_if #(.IN_W(2), .LEN_W(11)) bus2 ();

    assign bus0.rx_dv = mii_dv;
    assign bus0.rx_er = mii_er;
    assign bus0.rxd   = mii_d;
    assign bus1.rx_dv = mii_dv;
    assign bus1.rx_er = mii_er;
    assign bus1.rxd   = mii_d;
    assign bus2.rx_dv = rmii_dv;
    assign bus2.rx_er = rmii_er;
    assign bus2.rxd   = rmii_d;

    mii_rx_deframer #(.IN_W(4), .MIN_PRE_SYM(c_MIN_PRE), .MAX_BYTES(c_MAX_BIG), .LEN_W(11))
        u_dut0 (.clock(clock), .reset(reset), .bus(bus0));
    mii_rx_deframer #(.IN_W(4), .MIN_PRE_SYM(c_MIN_PRE), .MAX_BYTES(c_MAX_SML), .LEN_W(11))
        u_dut1 (.clock(clock), .reset(reset), .bus(bus1));
    mii_rx_deframer #(.IN_W(2), .MIN_PRE_SYM(c_MIN_PRE), .MAX_BYTES(c_MAX_BIG), .LEN_W(11))
        u_dut2 (.clock(clock), .reset(reset), .bus(bus2));

    task automatic chk(input string name, input int id, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s dut%0d got=%0h want=%0h", name, id, got, want);
        end
    endtask

    function automatic logic [3:0] pre_sym(input int w);
        return (w == 4) ? 4'h5 : 4'h1;
    endfunction

    function automatic logic [3:0] sfd_sym(input int w);
        return (w == 4) ? 4'hD : 4'h3;
    endfunction

    task automatic push_ev(input int id, input ev_t e);
        case (id)
            0: q0.push_back(e);
            1: q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    task automatic pop_ev(input int id, output bit ok, output ev_t e);
        ok = 1'b0;
        e  = '{default: 0};
        case (id)
            0: if (q0.size() > 0) begin e = q0.pop_front(); ok = 1'b1; end
            1: if (q1.size() > 0) begin e = q1.pop_front(); ok = 1'b1; end
            default: if (q2.size() > 0) begin e = q2.pop_front(); ok = 1'b1; end
        endcase
    endtask

    // Reference: parse one rx_dv run as a flat symbol list.
    task automatic model_run(input int id, input int w, input int maxb,
                             input logic [3:0] syms[$], input bit ers[$], input bit with_eof);
        int  npre, ndata, nbytes, spb, val;
        bit  erx;
        ev_t e;
        spb = 8 / w;
        if (!armed || syms.size() == 0) return;
        if (syms[0] != pre_sym(w)) return;
        npre = 0;
        while (npre < syms.size() && syms[npre] == pre_sym(w)) npre++;
        if (npre == syms.size()) return;
        if (syms[npre] != sfd_sym(w)) return;
        erx = 1'b0;
        for (int i = npre; i < syms.size(); i++) if (ers[i]) erx = 1'b1;
        ndata  = syms.size() - npre - 1;
        nbytes = ndata / spb;
        for (int b = 0; b < nbytes && b < maxb; b++) begin
            val = 0;
            for (int k = 0; k < spb; k++)
                val = val | (int'(syms[npre + 1 + b * spb + k]) << (k * w));
            e = '{default: 0};
            e.b   = 8'(val);
            e.sof = (b == 0);
            push_ev(id, e);
        end
        if (with_eof) begin
            e = '{default: 0};
            e.is_eof = 1'b1;
            e.len    = (nbytes < maxb) ? nbytes : maxb;
            e.ea     = (ndata % spb) != 0;
            e.erx    = erx;
            e.ep     = npre < c_MIN_PRE;
            e.el     = nbytes > maxb;
            push_ev(id, e);
        end
    endtask

    task automatic clr();
        s_q.delete();
        e_q.delete();
    endtask

    task automatic add_sym(input logic [3:0] v, input bit er);
        s_q.push_back(v);
        e_q.push_back(er);
    endtask

    task automatic add_pre(input int w, input int n);
        repeat (n) add_sym(pre_sym(w), 1'b0);
    endtask

    task automatic add_byte(input int w, input logic [7:0] b, input bit er);
        for (int k = 0; k < 8 / w; k++)
            add_sym(4'((b >> (k * w)) & ((1 << w) - 1)), er);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clock); #1;
            mii_dv = 1'b0; mii_er = 1'b0; mii_d = '0;
            rmii_dv = 1'b0; rmii_er = 1'b0; rmii_d = '0;
        end
    endtask

    task automatic drive(input int w, input int gap);
        if (w == 4) begin
            model_run(0, 4, c_MAX_BIG, s_q, e_q, 1'b1);
            model_run(1, 4, c_MAX_SML, s_q, e_q, 1'b1);
        end else begin
            model_run(2, 2, c_MAX_BIG, s_q, e_q, 1'b1);
        end
        foreach (s_q[i]) begin
            @(posedge clock); #1;
            if (w == 4) begin
                mii_dv = 1'b1; mii_d = s_q[i]; mii_er = e_q[i];
            end else begin
                rmii_dv = 1'b1; rmii_d = s_q[i][1:0]; rmii_er = e_q[i];
            end
        end
        idle(gap);
        armed = 1'b1;
    endtask

    task automatic rand_frame(input int w);
        int         npre, kind, nb, extra;
        logic [3:0] mask;
        mask = (w == 4) ? 4'hF : 4'h3;
        npre = $urandom_range(1, 12);
        kind = $urandom_range(0, 9);
        nb   = $urandom_range(0, 7);
        clr();
        if (kind == 0) add_sym(4'($urandom) & mask, 1'b0);
        for (int i = 0; i < npre; i++) add_sym(pre_sym(w), $urandom_range(0, 15) == 0);
        if (kind == 1) add_sym(4'($urandom) & mask, 1'b0);
        else if (kind != 2) add_sym(sfd_sym(w), $urandom_range(0, 15) == 0);
        if (kind != 2) begin
            for (int b = 0; b < nb; b++) add_byte(w, 8'($urandom), $urandom_range(0, 15) == 0);
            extra = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 8 / w - 1) : 0;
            for (int i = 0; i < extra; i++) add_sym(4'($urandom) & mask, 1'b0);
        end
        drive(w, $urandom_range(1, 3));
    endtask

    task automatic mon(input int id, input logic bv, input logic [7:0] bo, input logic sf,
                       input logic ef, input logic [10:0] fl, input logic ea, input logic erx,
                       input logic ep, input logic el);
        ev_t x;
        bit  ok;
        if (bv) begin
            pop_ev(id, ok, x);
            if (!ok) chk("byte_unexpected", id, 32'd1, 32'd0);
            else begin
                chk("byte_vs_eof_order", id, 32'(x.is_eof), 32'd0);
                chk("byte_out", id, 32'(bo), 32'(x.b));
                chk("sof", id, 32'(sf), 32'(x.sof));
            end
        end else begin
            chk("sof_without_valid", id, 32'(sf), 32'd0);
        end
        if (ef) begin
            pop_ev(id, ok, x);
            if (!ok) chk("eof_unexpected", id, 32'd1, 32'd0);
            else begin
                chk("eof_vs_byte_order", id, 32'(x.is_eof), 32'd1);
                chk("frame_len", id, 32'(fl), 32'(x.len));
                chk("err_align", id, 32'(ea), 32'(x.ea));
                chk("err_rx", id, 32'(erx), 32'(x.erx));
                chk("err_pre", id, 32'(ep), 32'(x.ep));
                chk("err_long", id, 32'(el), 32'(x.el));
            end
        end else begin
            chk("status_without_eof", id, 32'({fl, ea, erx, ep, el}), 32'd0);
        end
    endtask

    always @(negedge clock) begin
        if (mon_en) begin
            mon(0, bus0.byte_valid, bus0.byte_out, bus0.sof, bus0.eof, bus0.frame_len,
                bus0.err_align, bus0.err_rx, bus0.err_pre, bus0.err_long);
            mon(1, bus1.byte_valid, bus1.byte_out, bus1.sof, bus1.eof, bus1.frame_len,
                bus1.err_align, bus1.err_rx, bus1.err_pre, bus1.err_long);
            mon(2, bus2.byte_valid, bus2.byte_out, bus2.sof, bus2.eof, bus2.frame_len,
                bus2.err_align, bus2.err_rx, bus2.err_pre, bus2.err_long);
        end
    end

    task automatic chk_reset_state();
        chk("reset_state", 0, 32'({bus0.byte_out, bus0.byte_valid, bus0.sof, bus0.eof, bus0.frame_len,
            bus0.err_align, bus0.err_rx, bus0.err_pre, bus0.err_long}), 32'd0);
        chk("reset_state", 1, 32'({bus1.byte_out, bus1.byte_valid, bus1.sof, bus1.eof, bus1.frame_len,
            bus1.err_align, bus1.err_rx, bus1.err_pre, bus1.err_long}), 32'd0);
        chk("reset_state", 2, 32'({bus2.byte_out, bus2.byte_valid, bus2.sof, bus2.eof, bus2.frame_len,
            bus2.err_align, bus2.err_rx, bus2.err_pre, bus2.err_long}), 32'd0);
    endtask

    initial begin
        logic [3:0] p_s[$];
        bit         p_e[$];
        int         pre_lens[3];
        pre_lens = '{3, 7, 9};

        repeat (3) @(posedge clock);
        @(negedge clock);
        chk_reset_state();
        @(posedge clock); #1;
        reset  = 1'b0;
        mon_en = 1'b1;
        @(posedge clock); #1;
        armed = 1'b1;

        // MII two-byte frame
        clr(); add_pre(4, 15); add_sym(4'hD, 1'b0);
        add_byte(4, 8'hA1, 1'b0); add_byte(4, 8'h3C, 1'b0);
        drive(4, 3);

        // RMII 64-byte frame
        clr(); add_pre(2, 31); add_sym(4'h3, 1'b0);
        for (int b = 0; b < 64; b++) add_byte(2, 8'(b), 1'b0);
        drive(2, 3);

        // trailing partial nibble
        clr(); add_pre(4, 8); add_sym(4'hD, 1'b0);
        add_byte(4, 8'h12, 1'b0); add_sym(4'h7, 1'b0);
        drive(4, 2);

        // short / borderline / long preamble
        foreach (pre_lens[i]) begin
            clr(); add_pre(4, pre_lens[i]); add_sym(4'hD, 1'b0);
            add_byte(4, 8'($urandom), 1'b0);
            drive(4, 2);
        end

        // six bytes with rx_er on the second byte: small instance overflows
        clr(); add_pre(4, 8); add_sym(4'hD, 1'b0);
        for (int b = 0; b < 6; b++) add_byte(4, 8'($urandom), b == 1);
        drive(4, 2);

        // SFD with no payload
        clr(); add_pre(4, 8); add_sym(4'hD, 1'b0);
        drive(4, 2);
        clr(); add_pre(2, 8); add_sym(4'h3, 1'b0);
        drive(2, 2);

        // rx_dv toggling every cycle
        repeat (6) begin
            clr(); add_sym(($urandom_range(0, 1) == 0) ? 4'h5 : 4'hD, 1'b0);
            drive(4, 1);
        end

        // reset on the first symbol of the third byte, rx_dv held high after
        clr(); add_pre(4, 8); add_sym(4'hD, 1'b0);
        for (int b = 0; b < 4; b++) add_byte(4, 8'($urandom), 1'b0);
        p_s.delete(); p_e.delete();
        for (int i = 0; i < 13; i++) begin p_s.push_back(s_q[i]); p_e.push_back(e_q[i]); end
        model_run(0, 4, c_MAX_BIG, p_s, p_e, 1'b0);
        model_run(1, 4, c_MAX_SML, p_s, p_e, 1'b0);
        for (int i = 0; i < 13; i++) begin
            @(posedge clock); #1;
            mii_dv = 1'b1; mii_d = s_q[i]; mii_er = e_q[i];
        end
        @(posedge clock); #1;
        reset = 1'b1; mii_d = s_q[13]; armed = 1'b0;
        @(posedge clock); #1;
        reset = 1'b0; mii_d = 4'h5;
        @(negedge clock);
        chk_reset_state();
        repeat (9) begin
            @(posedge clock); #1;
            mii_d = ($urandom_range(0, 1) == 0) ? 4'h5 : 4'($urandom);
        end
        idle(1);
        @(posedge clock); #1;
        armed = 1'b1;
        clr(); add_pre(4, 10); add_sym(4'hD, 1'b0);
        for (int b = 0; b < 3; b++) add_byte(4, 8'($urandom), 1'b0);
        drive(4, 2);

        repeat (40) rand_frame(4);
        repeat (20) rand_frame(2);

        idle(10);
        chk("queue_drained", 0, 32'(q0.size()), 32'd0);
        chk("queue_drained", 1, 32'(q1.size()), 32'd0);
        chk("queue_drained", 2, 32'(q2.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
